// File: rtl/ysyx_22040175_pipe_buf.sv
// ---------------------------------------------------------------------------
// ysyx_22040175_pipe_buf
//
// Elastic pipeline register placed at every stage boundary (IF/ID/EX/MEM/WB).
// Upstream and downstream use a valid/ready handshake. With SKID=1 the buffer
// holds up to two entries, and in_ready_o comes straight from a flop, so no
// combinational path crosses the boundary. With SKID=0 it holds a single entry,
// and ready is passed through combinationally. A flush kills every held entry
// when a branch or jump redirect occurs. Two saturating counters record stall
// cycles and bubble cycles for performance analysis.
//
// Parameters
//   WIDTH : payload width in bits
//   SKID  : 1 = two entries with registered ready, 0 = one entry with comb ready
//   CNT_W : width of the stall and bubble counters
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   rst_n        : asynchronous reset, active low
//   flush_i      : synchronous kill of all held entries
//   clr_cnt_i    : synchronous clear of both counters
//   in_valid_i   : upstream entry valid
//   in_ready_o   : buffer accepts an entry this cycle
//   in_data_i    : upstream payload
//   out_valid_o  : downstream entry valid
//   out_ready_i  : downstream accepts the entry
//   out_data_o   : downstream payload (main register)
//   occ_o        : number of entries held (0, 1 or 2)
//   stall_cnt_o  : cycles with out_valid_o=1 and out_ready_i=0
//   bubble_cnt_o : cycles with out_valid_o=0
// ---------------------------------------------------------------------------
module ysyx_22040175_pipe_buf #(
    parameter int WIDTH = 192,
    parameter int SKID  = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             clr_cnt_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occ_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [WIDTH-1:0]   main_q;
    logic [WIDTH-1:0]   main_n;
    logic [WIDTH-1:0]   skid_q;
    logic [WIDTH-1:0]   skid_n;
    logic               in_ready_q;
    logic [CNT_W-1:0]   stall_q;
    logic [CNT_W-1:0]   bubble_q;
    logic               in_fire;
    logic               out_fire;

    // The head of the queue is always held in the main register, so the
    // downstream stage sees a flop output with no muxing in front of it.
    assign out_valid_o  = (state_q != ST_EMPTY);
    assign out_data_o   = main_q;
    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;

    // With the skid entry present, ready is the registered "not full" flag.
    // Without the skid entry, the single slot can be refilled in the same
    // cycle it drains, so ready must look at out_ready_i directly.
    assign in_ready_o = (SKID != 0) ? in_ready_q : (!out_valid_o || out_ready_i);

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    // Map the state to an occupancy count that the hazard logic can observe.
    always_comb begin
        occ_o = 2'd0;
        case (state_q)
            ST_ONE:  occ_o = 2'd1;
            ST_FULL: occ_o = 2'd2;
            default: occ_o = 2'd0;
        endcase
    end

    // Next-state and data-path steering. A flush overrides everything: any
    // entry arriving in the same cycle is dropped, and both registers are
    // zeroed so a killed instruction cannot leak into later stages. In the
    // FULL state the skid entry is older than anything upstream, so it moves
    // into the main register as soon as the head drains.
    always_comb begin
        state_n = state_q;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush_i) begin
            state_n = ST_EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_n = ST_ONE;
                        main_n  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_n = in_data_i;
                    end else if (out_fire) begin
                        state_n = ST_EMPTY;
                    end else if (in_fire && (SKID != 0)) begin
                        state_n = ST_FULL;
                        skid_n  = in_data_i;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_n = ST_ONE;
                        main_n  = skid_q;
                        skid_n  = '0;
                    end
                end
                default: begin
                    state_n = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers. The ready flop is loaded from the next
    // state, so it is low exactly while the buffer holds two entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_n;
            main_q     <= main_n;
            skid_q     <= skid_n;
            in_ready_q <= (state_n != ST_FULL);
        end
    end

    // Performance counters. Both counters saturate instead of wrapping, so a
    // long run still shows that the limit was reached. A clear wins over an
    // increment. A flush does not touch the counters; the flush cycle itself
    // is classified by the valid flag it started with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else if (clr_cnt_i) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (!out_valid_o && (bubble_q != {CNT_W{1'b1}})) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040175_pipe_buf.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040175_pipe_buf
//
// This bench drives two instances of the buffer:
//   dut_a : SKID=1 with 3-bit counters, so saturation is reached quickly
//   dut_b : SKID=0 with 4-bit counters
// Each instance has a queue model. The model advances on the clock and is
// compared against the DUT on every falling edge. Directed sequences also
// carry literal expectations that pin down the model.
// ---------------------------------------------------------------------------
module tb_ysyx_22040175_pipe_buf;

    localparam int W     = 8;
    localparam int A_MAX = 7;
    localparam int B_MAX = 15;

    logic         clk;

    logic         a_rst_n, a_flush, a_clr, a_in_valid, a_in_ready;
    logic         a_out_valid, a_out_ready;
    logic [W-1:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;
    logic [2:0]   a_stall, a_bubble;

    logic         b_rst_n, b_flush, b_clr, b_in_valid, b_in_ready;
    logic         b_out_valid, b_out_ready;
    logic [W-1:0] b_in_data, b_out_data;
    logic [1:0]   b_occ;
    logic [3:0]   b_stall, b_bubble;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [W-1:0] a_mq[$];
    logic [W-1:0] b_mq[$];
    int           a_stall_m, a_bubble_m, b_stall_m, b_bubble_m;
    logic [W-1:0] a_seen[$];

    ysyx_22040175_pipe_buf #(.WIDTH(W), .SKID(1), .CNT_W(3)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .flush_i(a_flush), .clr_cnt_i(a_clr),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
        .occ_o(a_occ), .stall_cnt_o(a_stall), .bubble_cnt_o(a_bubble)
    );

    ysyx_22040175_pipe_buf #(.WIDTH(W), .SKID(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .flush_i(b_flush), .clr_cnt_i(b_clr),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .occ_o(b_occ), .stall_cnt_o(b_stall), .bubble_cnt_o(b_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus for instance 0 (A) or 1 (B).
    task automatic applyStimulus(input int which, input logic v, input logic [W-1:0] d,
                                 input logic ordy, input logic fl, input logic clr);
        if (which == 0) begin
            a_in_valid = v; a_in_data = d; a_out_ready = ordy; a_flush = fl; a_clr = clr;
        end else begin
            b_in_valid = v; b_in_data = d; b_out_ready = ordy; b_flush = fl; b_clr = clr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkSeen(input string name, input logic [W-1:0] e0,
                             input logic [W-1:0] e1, input logic [W-1:0] e2);
        logic [W-1:0] exp_v[3];
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2;
        checkOutput({name, "_count"}, a_seen.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s_%0d", name, i),
                        (i < a_seen.size()) ? 32'(a_seen[i]) : 32'hDEAD, 32'(exp_v[i]));
        end
    endtask

    // Model of A: a queue holding at most two entries. Ready means "not full".
    always @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            a_mq.delete();
            a_stall_m  = 0;
            a_bubble_m = 0;
        end else begin
            automatic bit in_f  = a_in_valid && (a_mq.size() < 2);
            automatic bit out_f = (a_mq.size() > 0) && a_out_ready;
            if (a_clr) begin
                a_stall_m = 0; a_bubble_m = 0;
            end else begin
                if (a_mq.size() > 0 && !a_out_ready && a_stall_m < A_MAX) a_stall_m++;
                if (a_mq.size() == 0 && a_bubble_m < A_MAX) a_bubble_m++;
            end
            if (a_flush) begin
                a_mq.delete();
            end else begin
                if (out_f) void'(a_mq.pop_front());
                if (in_f) a_mq.push_back(a_in_data);
            end
        end
    end

    // Model of B: a single slot. It may refill in the same cycle that it drains.
    always @(posedge clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            b_mq.delete();
            b_stall_m  = 0;
            b_bubble_m = 0;
        end else begin
            automatic bit in_f  = b_in_valid && (b_mq.size() == 0 || b_out_ready);
            automatic bit out_f = (b_mq.size() > 0) && b_out_ready;
            if (b_clr) begin
                b_stall_m = 0; b_bubble_m = 0;
            end else begin
                if (b_mq.size() > 0 && !b_out_ready && b_stall_m < B_MAX) b_stall_m++;
                if (b_mq.size() == 0 && b_bubble_m < B_MAX) b_bubble_m++;
            end
            if (b_flush) begin
                b_mq.delete();
            end else begin
                if (out_f) void'(b_mq.pop_front());
                if (in_f) b_mq.push_back(b_in_data);
            end
        end
    end

    // Compare both DUTs against their models away from the active edge.
    always @(negedge clk) begin
        checkOutput("a_in_ready",  a_in_ready,  (a_mq.size() < 2) ? 1 : 0);
        checkOutput("a_out_valid", a_out_valid, (a_mq.size() > 0) ? 1 : 0);
        checkOutput("a_occ",       a_occ,       a_mq.size());
        checkOutput("a_stall",     a_stall,     a_stall_m);
        checkOutput("a_bubble",    a_bubble,    a_bubble_m);
        if (a_mq.size() > 0) checkOutput("a_out_data", a_out_data, a_mq[0]);
        if (a_out_valid && a_out_ready) a_seen.push_back(a_out_data);

        checkOutput("b_in_ready",  b_in_ready,  (b_mq.size() == 0 || b_out_ready) ? 1 : 0);
        checkOutput("b_out_valid", b_out_valid, (b_mq.size() > 0) ? 1 : 0);
        checkOutput("b_occ",       b_occ,       b_mq.size());
        checkOutput("b_stall",     b_stall,     b_stall_m);
        checkOutput("b_bubble",    b_bubble,    b_bubble_m);
        if (b_mq.size() > 0) checkOutput("b_out_data", b_out_data, b_mq[0]);
    end

    initial begin
        a_rst_n = 0; a_flush = 0; a_clr = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_rst_n = 0; b_flush = 0; b_clr = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        #12;
        checkOutput("rst_a_in_ready", a_in_ready, 1);
        checkOutput("rst_a_out_data", a_out_data, 0);
        checkOutput("rst_a_occ", a_occ, 0);
        a_rst_n = 1; b_rst_n = 1;
        @(posedge clk); #1;

        // Back-to-back streaming with no backpressure.
        a_seen.delete();
        applyStimulus(0, 1, 8'hA1, 1, 0, 0);
        checkOutput("t1_data_c1", a_out_data, 8'hA1);
        applyStimulus(0, 1, 8'hA2, 1, 0, 0);
        checkOutput("t1_occ_c2", a_occ, 1);
        applyStimulus(0, 1, 8'hA3, 1, 0, 0);
        checkOutput("t1_data_c3", a_out_data, 8'hA3);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        checkSeen("t1_seen", 8'hA1, 8'hA2, 8'hA3);
        checkOutput("t1_stall", a_stall, 0);

        // Fill the skid entry and hold the third entry upstream.
        a_seen.delete();
        applyStimulus(0, 1, 8'h11, 0, 0, 0);
        applyStimulus(0, 1, 8'h22, 0, 0, 0);
        checkOutput("t2_occ", a_occ, 2);
        checkOutput("t2_in_ready", a_in_ready, 0);
        applyStimulus(0, 1, 8'h33, 0, 0, 0);
        applyStimulus(0, 1, 8'h33, 1, 0, 0);
        applyStimulus(0, 1, 8'h33, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        checkSeen("t2_seen", 8'h11, 8'h22, 8'h33);

        // A flush while FULL drops every entry, including the one arriving now.
        a_seen.delete();
        applyStimulus(0, 1, 8'h44, 0, 0, 0);
        applyStimulus(0, 1, 8'h45, 0, 0, 0);
        applyStimulus(0, 1, 8'h55, 0, 1, 0);
        checkOutput("t3_occ", a_occ, 0);
        checkOutput("t3_out_valid", a_out_valid, 0);
        checkOutput("t3_in_ready", a_in_ready, 1);
        checkOutput("t3_out_data", a_out_data, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 1, 0, 0);
        checkOutput("t3_seen_none", a_seen.size(), 0);

        // Stall counting, data stability and saturation of the 3-bit counter.
        applyStimulus(0, 0, 8'h00, 0, 0, 1);
        checkOutput("t4_clr_bubble", a_bubble, 0);
        applyStimulus(0, 1, 8'h66, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("t4_stall5", a_stall, 5);
        checkOutput("t4_data_hold", a_out_data, 8'h66);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("t4_stall_sat", a_stall, 7);
        checkOutput("t4_data_hold2", a_out_data, 8'h66);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        checkOutput("t4_drained", a_out_valid, 0);

        // SKID=0: ready follows out_ready combinationally.
        applyStimulus(1, 1, 8'hB1, 0, 0, 0);
        b_in_valid = 1; b_in_data = 8'hB2; b_out_ready = 0;
        #1;
        checkOutput("t5_ready_low", b_in_ready, 0);
        @(posedge clk); #1;
        checkOutput("t5_hold_data", b_out_data, 8'hB1);
        b_out_ready = 1;
        #1;
        checkOutput("t5_ready_high", b_in_ready, 1);
        @(posedge clk); #1;
        checkOutput("t5_occ", b_occ, 1);
        checkOutput("t5_data", b_out_data, 8'hB2);
        applyStimulus(1, 0, 8'h00, 1, 0, 0);
        checkOutput("t5_drained", b_out_valid, 0);

        // An asynchronous reset mid-stream with two entries held.
        applyStimulus(0, 1, 8'h71, 0, 0, 0);
        applyStimulus(0, 1, 8'h72, 0, 0, 0);
        checkOutput("t6_occ_pre", a_occ, 2);
        a_in_valid = 0;
        #2;
        a_rst_n = 0;
        #1;
        checkOutput("t6_out_valid", a_out_valid, 0);
        checkOutput("t6_out_data", a_out_data, 0);
        checkOutput("t6_occ", a_occ, 0);
        checkOutput("t6_stall", a_stall, 0);
        checkOutput("t6_bubble", a_bubble, 0);
        checkOutput("t6_in_ready", a_in_ready, 1);
        @(negedge clk); #2;
        a_rst_n = 1;
        @(posedge clk); #1;
        applyStimulus(0, 1, 8'h81, 1, 0, 0);
        checkOutput("t6_first_valid", a_out_valid, 1);
        checkOutput("t6_first_data", a_out_data, 8'h81);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
